id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- Decode-to-execute pipeline stage that sits directly upstream of the ALU.
- Captures decoded instruction fields and resolves operand forwarding from the EX/MEM and MEM/WB stages.
- Selects operand A (rs1 or pc) and operand B (rs2 or imm), and registers the operands and ALU control word that drive the ALU inputs.
- Detects load-use hazards, inserts bubbles, and supports stall (valid/ready) and flush.

Parameters:
XLEN, 32, datapath width; o_a, o_b and o_rs2 feed the ALU operands and store data.
CTRL_W, 16, ALU control word width; matches the ALU's i_aluCtrl.
REG_AW, 5, register address width.

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_valid  in  1  decode presents an instruction
o_ready  out  1  stage accepts the instruction this cycle
i_pc, i_rs1_data, i_rs2_data, i_imm  in  XLEN each  decoded pc, register-file reads, immediate
i_rs1_addr, i_rs2_addr, i_rd_addr  in  REG_AW each  source and destination register indices
i_useRs1, i_useRs2  in  1 each  instruction actually reads rs1 / rs2
i_selA  in  1  0 selects rs1, 1 selects pc
i_selB  in  1  0 selects rs2, 1 selects imm
i_aluCtrl  in  CTRL_W  one-hot ALU operation code
i_isLoad, i_regWrite  in  1 each  instruction is a load; instruction writes rd
i_flush  in  1  squash (branch/jump redirect)
i_exmem_regWrite, i_exmem_rd, i_exmem_result  in  1/REG_AW/XLEN  EX/MEM forwarding source
i_memwb_regWrite, i_memwb_rd, i_memwb_result  in  1/REG_AW/XLEN  MEM/WB forwarding source
i_ready  in  1  execute/downstream can take the stage content
o_valid  out  1  stage holds a valid instruction
o_a, o_b  out  XLEN each  registered ALU operands
o_aluCtrl  out  CTRL_W  registered ALU control word
o_rs2  out  XLEN  forwarded rs2 value, used as store data
o_pc  out  XLEN  pc of the held instruction
o_rd  out  REG_AW  destination register
o_regWrite, o_isLoad  out  1 each  registered control flags

Behaviour:
- Reset (async, i_rst_n=0): all registered outputs are 0, including o_valid, o_aluCtrl (ALU then outputs 0) and o_regWrite.
- Forwarding (combinational, applied per source rs1 and rs2, before operand select):
  - Index 0 never forwards; raw register-file data is used.
  - Else if i_exmem_regWrite and i_exmem_rd==rs, use i_exmem_result.
  - Else if i_memwb_regWrite and i_memwb_rd==rs, use i_memwb_result.
  - Else use i_rsN_data. EX/MEM has priority over MEM/WB.
- Operand select: A = i_selA ? i_pc : fwd_rs1; B = i_selB ? i_imm : fwd_rs2. o_rs2 always carries fwd_rs2.
- Hazard: hazard = o_valid & o_isLoad & (o_rd!=0) & ((i_useRs1 & i_rs1_addr==o_rd) | (i_useRs2 & i_rs2_addr==o_rd)).
- Advance condition: adv = !o_valid | i_ready.
- o_ready = i_flush | (adv & !hazard). This output is combinational.
- Register update priority at each rising edge:
  1. i_flush: o_valid<=0, o_regWrite<=0, o_isLoad<=0. Any upstream instruction is consumed and dropped.
  2. adv & hazard: insert a bubble. o_valid<=0, o_regWrite<=0, o_isLoad<=0, o_aluCtrl<=0. The upstream instruction is held and re-presented next cycle, when hazard has cleared.
  3. adv & i_valid: load the full payload and set o_valid<=1.
  4. adv & !i_valid: o_valid<=0, o_regWrite<=0.
  5. Otherwise (stall): hold all outputs unchanged.
- Latency: one cycle from acceptance to the operands appearing on o_a/o_b. Throughput is one instruction per cycle when no hazard or stall is present.
- Stall with forwarding: forwarding is evaluated only at capture. Operands held during a stall are not re-forwarded.
- Reset asserted mid-operation: the stage empties immediately and the in-flight instruction is lost.

Test Plan:
- Reset then single ADD: rs1=x1=5, rs2=x2=7, selA=selB=0 -> one cycle later o_valid=1, o_a=5, o_b=7, o_aluCtrl=ALU_ADD; after reset release all outputs start at 0.
- Forwarding priority: rs1=x3, exmem writes x3=0x11, memwb writes x3=0x22 -> o_a=0x11. With exmem_regWrite=0 -> o_a=0x22. With rs1=x0 and exmem_rd=0 -> o_a=register data (0).
- Load-use: LW x5 held in stage, next instruction uses rs2=x5 -> o_ready=0 for one cycle and a bubble is inserted (o_valid=0, o_regWrite=0). The instruction is accepted on the following cycle with o_ready=1. Same case with i_useRs2=0 -> no bubble.
- Downstream stall: o_valid=1, i_ready=0 for 3 cycles with new i_valid -> o_ready=0 and outputs stable. When i_ready returns to 1, the new instruction loads on the next edge.
- Flush: i_flush=1 while the stage is valid and i_valid=1 -> o_ready=1, next cycle o_valid=0 and o_regWrite=0. A simultaneous hazard and stall are ignored.
- AUIPC-style select: selA=1, selB=1, pc=0x1000, imm=0x2000 -> o_a=0x1000, o_b=0x2000, o_rs2=forwarded rs2 value.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bus: decoded instruction, forwarding sources and the
// registered operand/control word handed to the ALU.
interface id_ex_stage_if #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 16,
    parameter int REG_AW = 5
);
    logic              i_valid;
    logic              o_ready;
    logic [XLEN-1:0]   i_pc;
    logic [XLEN-1:0]   i_rs1_data;
    logic [XLEN-1:0]   i_rs2_data;
    logic [XLEN-1:0]   i_imm;
    logic [REG_AW-1:0] i_rs1_addr;
    logic [REG_AW-1:0] i_rs2_addr;
    logic [REG_AW-1:0] i_rd_addr;
    logic              i_useRs1;
    logic              i_useRs2;
    logic              i_selA;
    logic              i_selB;
    logic [CTRL_W-1:0] i_aluCtrl;
    logic              i_isLoad;
    logic              i_regWrite;
    logic              i_flush;
    logic              i_exmem_regWrite;
    logic [REG_AW-1:0] i_exmem_rd;
    logic [XLEN-1:0]   i_exmem_result;
    logic              i_memwb_regWrite;
    logic [REG_AW-1:0] i_memwb_rd;
    logic [XLEN-1:0]   i_memwb_result;
    logic              i_ready;
    logic              o_valid;
    logic [XLEN-1:0]   o_a;
    logic [XLEN-1:0]   o_b;
    logic [CTRL_W-1:0] o_aluCtrl;
    logic [XLEN-1:0]   o_rs2;
    logic [XLEN-1:0]   o_pc;
    logic [REG_AW-1:0] o_rd;
    logic              o_regWrite;
    logic              o_isLoad;

    modport slave (
        input  i_valid, i_pc, i_rs1_data, i_rs2_data, i_imm,
               i_rs1_addr, i_rs2_addr, i_rd_addr, i_useRs1, i_useRs2,
               i_selA, i_selB, i_aluCtrl, i_isLoad, i_regWrite, i_flush,
               i_exmem_regWrite, i_exmem_rd, i_exmem_result,
               i_memwb_regWrite, i_memwb_rd, i_memwb_result, i_ready,
        output o_ready, o_valid, o_a, o_b, o_aluCtrl, o_rs2, o_pc, o_rd,
               o_regWrite, o_isLoad
    );

    modport master (
        output i_valid, i_pc, i_rs1_data, i_rs2_data, i_imm,
               i_rs1_addr, i_rs2_addr, i_rd_addr, i_useRs1, i_useRs2,
               i_selA, i_selB, i_aluCtrl, i_isLoad, i_regWrite, i_flush,
               i_exmem_regWrite, i_exmem_rd, i_exmem_result,
               i_memwb_regWrite, i_memwb_rd, i_memwb_result, i_ready,
        input  o_ready, o_valid, o_a, o_b, o_aluCtrl, o_rs2, o_pc, o_rd,
               o_regWrite, o_isLoad
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: operand forwarding and select, load-use bubble
// insertion, valid/ready stall and flush.
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 16,
    parameter int REG_AW = 5
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    id_ex_stage_if.slave  bus
);
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            hazard;
    logic            adv;

    // EX/MEM is the younger result, so it wins over MEM/WB; x0 never forwards.
    always_comb begin
        fwd_rs1 = bus.i_rs1_data;
        if (bus.i_rs1_addr != '0) begin
            if (bus.i_exmem_regWrite && (bus.i_exmem_rd == bus.i_rs1_addr))
                fwd_rs1 = bus.i_exmem_result;
            else if (bus.i_memwb_regWrite && (bus.i_memwb_rd == bus.i_rs1_addr))
                fwd_rs1 = bus.i_memwb_result;
        end
    end

    always_comb begin
        fwd_rs2 = bus.i_rs2_data;
        if (bus.i_rs2_addr != '0) begin
            if (bus.i_exmem_regWrite && (bus.i_exmem_rd == bus.i_rs2_addr))
                fwd_rs2 = bus.i_exmem_result;
            else if (bus.i_memwb_regWrite && (bus.i_memwb_rd == bus.i_rs2_addr))
                fwd_rs2 = bus.i_memwb_result;
        end
    end

    assign op_a = bus.i_selA ? bus.i_pc  : fwd_rs1;
    assign op_b = bus.i_selB ? bus.i_imm : fwd_rs2;

    // A load held here has no data yet, so a dependent instruction must wait a cycle.
    assign hazard = bus.o_valid && bus.o_isLoad && (bus.o_rd != '0) &&
                    ((bus.i_useRs1 && (bus.i_rs1_addr == bus.o_rd)) ||
                     (bus.i_useRs2 && (bus.i_rs2_addr == bus.o_rd)));
    assign adv         = !bus.o_valid || bus.i_ready;
    assign bus.o_ready = bus.i_flush || (adv && !hazard);

    // Flush outranks everything; payload fields not listed in a branch simply hold.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bus.o_valid    <= 1'b0;
            bus.o_a        <= '0;
            bus.o_b        <= '0;
            bus.o_aluCtrl  <= '0;
            bus.o_rs2      <= '0;
            bus.o_pc       <= '0;
            bus.o_rd       <= '0;
            bus.o_regWrite <= 1'b0;
            bus.o_isLoad   <= 1'b0;
        end else if (bus.i_flush) begin
            bus.o_valid    <= 1'b0;
            bus.o_regWrite <= 1'b0;
            bus.o_isLoad   <= 1'b0;
        end else if (adv && hazard) begin
            bus.o_valid    <= 1'b0;
            bus.o_regWrite <= 1'b0;
            bus.o_isLoad   <= 1'b0;
            bus.o_aluCtrl  <= '0;
        end else if (adv && bus.i_valid) begin
            bus.o_valid    <= 1'b1;
            bus.o_a        <= op_a;
            bus.o_b        <= op_b;
            bus.o_aluCtrl  <= bus.i_aluCtrl;
            bus.o_rs2      <= fwd_rs2;
            bus.o_pc       <= bus.i_pc;
            bus.o_rd       <= bus.i_rd_addr;
            bus.o_regWrite <= bus.i_regWrite;
            bus.o_isLoad   <= bus.i_isLoad;
        end else if (adv) begin
            bus.o_valid    <= 1'b0;
            bus.o_regWrite <= 1'b0;
        end
    end
endmodule
